// File: rtl/ffsr_pkg.sv
// Shared types and thermometer-code helpers for the FFSR pulse generator.
// Helpers take codes zero-extended to THERMO_MAX_W, so they cover any INPUT_SIZE up to 32.
package ffsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } ffsr_state_e;

  localparam int PACE_W       = 4;
  localparam int THERMO_MAX_W = 32;
  localparam int COUNT_W      = 6;

  // A legal code is a run of ones at the low end: v & (v+1) clears to zero.
  function automatic logic is_thermo(input logic [THERMO_MAX_W-1:0] code);
    return (code & (code + 32'd1)) == '0;
  endfunction

  function automatic logic [COUNT_W-1:0] thermo_count(input logic [THERMO_MAX_W-1:0] code);
    return COUNT_W'($countones(code));
  endfunction

endpackage

// File: rtl/ffsr_thermo_check.sv
// Combinational validity check and popcount of a thermometer code.
module ffsr_thermo_check
  import ffsr_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [0:W-1]  i_code,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  // Index W-1 lands on bit 0, so the ones stay at the low end after extension.
  logic [THERMO_MAX_W-1:0] w_ext;

  assign w_ext   = THERMO_MAX_W'(i_code);
  assign o_valid = is_thermo(w_ext);
  assign o_count = CW'(thermo_count(w_ext));

endmodule

// File: rtl/ffsr_pulse_gen.sv
// Drives rst/inc/dec/init of a downstream thermometer FFSR toward absolute targets.
// Optional FFSR_PULSE_GEN_PACE_EN adds a gap input that spaces successive pulses.
module ffsr_pulse_gen
  import ffsr_pkg::*;
#(
  parameter int INPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [0:INPUT_SIZE-1] load_val,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [0:INPUT_SIZE-1] target,
`ifdef FFSR_PULSE_GEN_PACE_EN
  input  logic [PACE_W-1:0]     gap,
`endif
  output logic                  ffsr_rst,
  output logic                  ffsr_inc,
  output logic                  ffsr_dec,
  output logic [0:INPUT_SIZE-1] ffsr_init,
  output logic [0:INPUT_SIZE-1] cur,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(INPUT_SIZE + 1);

  ffsr_state_e           r_state, w_state_nx;
  logic [0:INPUT_SIZE-1] r_cur, w_cur_nx;
  logic [0:INPUT_SIZE-1] r_init, w_init_nx;
  logic [CW-1:0]         r_tgt_cnt, w_tgt_cnt_nx;
  logic                  r_rst, r_inc, r_dec, r_done, r_err, r_ready;
  logic                  w_rst_nx, w_inc_nx, w_dec_nx, w_done_nx, w_err_nx;

  logic [0:INPUT_SIZE-1] w_chk_code;
  logic                  w_chk_valid, w_cur_valid;
  logic [CW-1:0]         w_chk_cnt, w_cur_cnt;
  logic                  w_load_ok, w_pace_busy;

  // load outranks req_valid, so the shared checker looks at load_val first.
  assign w_chk_code = load ? load_val : target;
  assign w_load_ok  = load & w_chk_valid;

  ffsr_thermo_check #(.W(INPUT_SIZE), .CW(CW)) u_chk_in (
    .i_code (w_chk_code),
    .o_valid(w_chk_valid),
    .o_count(w_chk_cnt)
  );

  ffsr_thermo_check #(.W(INPUT_SIZE), .CW(CW)) u_chk_cur (
    .i_code (r_cur),
    .o_valid(w_cur_valid),
    .o_count(w_cur_cnt)
  );

`ifdef FFSR_PULSE_GEN_PACE_EN
  logic [PACE_W-1:0] r_gap, w_gap_nx;
  logic [PACE_W-1:0] r_pace, w_pace_nx;
  assign w_pace_busy = (r_pace != '0);
`else
  assign w_pace_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (!load && req_valid && w_chk_valid) w_state_nx = STEP;
      STEP: begin
        if (w_load_ok || !w_cur_valid) w_state_nx = IDLE;
        else if (!w_pace_busy && (w_cur_cnt == r_tgt_cnt)) w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_rst_nx     = 1'b0;
    w_inc_nx     = 1'b0;
    w_dec_nx     = 1'b0;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;
    w_cur_nx     = r_cur;
    w_init_nx    = r_init;
    w_tgt_cnt_nx = r_tgt_cnt;
`ifdef FFSR_PULSE_GEN_PACE_EN
    w_pace_nx    = r_pace;
    w_gap_nx     = r_gap;
`endif
    // A load is honoured in every state; in STEP it drops any pending pulses.
    if (w_load_ok) begin
      w_rst_nx  = 1'b1;
      w_init_nx = load_val;
      w_cur_nx  = load_val;
`ifdef FFSR_PULSE_GEN_PACE_EN
      w_pace_nx = '0;
`endif
    end else if (load) begin
      w_err_nx = 1'b1;
    end
    unique case (r_state)
      IDLE: begin
        if (!load && req_valid) begin
          if (w_chk_valid) begin
            w_tgt_cnt_nx = w_chk_cnt;
`ifdef FFSR_PULSE_GEN_PACE_EN
            w_gap_nx  = gap;
            w_pace_nx = '0;
`endif
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end
      STEP: begin
        if (!w_load_ok) begin
          // A corrupted mirror is reported rather than walked.
          if (!w_cur_valid) begin
            w_err_nx = 1'b1;
          end else if (w_pace_busy) begin
`ifdef FFSR_PULSE_GEN_PACE_EN
            w_pace_nx = r_pace - 1'b1;
`endif
          end else if (w_cur_cnt < r_tgt_cnt) begin
            w_inc_nx = 1'b1;
            w_cur_nx = {r_cur[1:INPUT_SIZE-1], 1'b1};
`ifdef FFSR_PULSE_GEN_PACE_EN
            w_pace_nx = ((w_cur_cnt + CW'(1)) == r_tgt_cnt) ? '0 : r_gap;
`endif
          end else if (w_cur_cnt > r_tgt_cnt) begin
            w_dec_nx = 1'b1;
            w_cur_nx = {1'b0, r_cur[0:INPUT_SIZE-2]};
`ifdef FFSR_PULSE_GEN_PACE_EN
            w_pace_nx = (w_cur_cnt == (r_tgt_cnt + CW'(1))) ? '0 : r_gap;
`endif
          end else begin
            w_done_nx = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur     <= '0;
      r_init    <= '0;
      r_tgt_cnt <= '0;
      r_rst     <= 1'b0;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
`ifdef FFSR_PULSE_GEN_PACE_EN
      r_gap     <= '0;
      r_pace    <= '0;
`endif
    end else begin
      r_cur     <= w_cur_nx;
      r_init    <= w_init_nx;
      r_tgt_cnt <= w_tgt_cnt_nx;
      r_rst     <= w_rst_nx;
      r_inc     <= w_inc_nx;
      r_dec     <= w_dec_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_ready   <= (w_state_nx == IDLE);
`ifdef FFSR_PULSE_GEN_PACE_EN
      r_gap     <= w_gap_nx;
      r_pace    <= w_pace_nx;
`endif
    end
  end

  assign req_ready = r_ready;
  assign ffsr_rst  = r_rst;
  assign ffsr_inc  = r_inc;
  assign ffsr_dec  = r_dec;
  assign ffsr_init = r_init;
  assign cur       = r_cur;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_ffsr_pulse_gen.sv
// Directed bench for ffsr_pulse_gen; flags are {ffsr_rst, ffsr_inc, ffsr_dec, done, err, req_ready}.
module tb_ffsr_pulse_gen;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [0:N-1] load_val;
  logic         req_valid;
  logic         req_ready;
  logic [0:N-1] target;
  logic         ffsr_rst, ffsr_inc, ffsr_dec, done, err;
  logic [0:N-1] ffsr_init, cur;
`ifdef FFSR_PULSE_GEN_PACE_EN
  logic [3:0]   gap = 4'd0;
`endif

  int errors = 0;
  int checks = 0;

  ffsr_pulse_gen #(.INPUT_SIZE(N)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .req_valid(req_valid), .req_ready(req_ready), .target(target),
`ifdef FFSR_PULSE_GEN_PACE_EN
    .gap(gap),
`endif
    .ffsr_rst(ffsr_rst), .ffsr_inc(ffsr_inc), .ffsr_dec(ffsr_dec),
    .ffsr_init(ffsr_init), .cur(cur), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {ffsr_rst, ffsr_inc, ffsr_dec, done, err, req_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; load_val = '0; req_valid = 1'b0; target = '0;
    repeat (2) tick();
    checks++;
    if (flags() >> 1 !== 6'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=00000", flags() >> 1);
    end
    checks++;
    if ({cur, ffsr_init} !== 16'h0) begin
      errors++; $display("FAIL reset_cur_init got=%b/%b exp=0/0", cur, ffsr_init);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    checks++;
    if (flags() !== 6'b000001) begin
      errors++; $display("FAIL reset_release got=%b exp=000001", flags());
    end
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 8'b00000111;
    tick();
    load = 1'b0;
    checks++;
    if (flags() !== 6'b100001) begin
      errors++; $display("FAIL load_flags got=%b exp=100001", flags());
    end
    checks++;
    if (cur !== 8'b00000111 || ffsr_init !== 8'b00000111) begin
      errors++; $display("FAIL load_value cur=%b init=%b exp=00000111", cur, ffsr_init);
    end
    tick();
    checks++;
    if (flags() !== 6'b000001 || cur !== 8'b00000111) begin
      errors++; $display("FAIL load_one_cycle flags=%b cur=%b exp=000001/00000111", flags(), cur);
    end
  endtask

  task automatic test_inc();
    logic [0:N-1] exp [0:2];
    exp = '{8'b00001111, 8'b00011111, 8'b00111111};
    req_valid = 1'b1; target = 8'b00111111;
    tick();
    req_valid = 1'b0;
    checks++;
    if (flags() !== 6'b000000) begin
      errors++; $display("FAIL inc_accept got=%b exp=000000", flags());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b010000 || cur !== exp[i]) begin
        errors++; $display("FAIL inc_step%0d flags=%b cur=%b exp=010000/%b", i, flags(), cur, exp[i]);
      end
    end
    tick();
    checks++;
    if (flags() !== 6'b000100 || cur !== 8'b00111111) begin
      errors++; $display("FAIL inc_done flags=%b cur=%b exp=000100/00111111", flags(), cur);
    end
    tick();
    checks++;
    if (flags() !== 6'b000001) begin
      errors++; $display("FAIL inc_ready got=%b exp=000001", flags());
    end
  endtask

  task automatic test_dec();
    logic [0:N-1] exp [0:4];
    exp = '{8'b00011111, 8'b00001111, 8'b00000111, 8'b00000011, 8'b00000001};
    req_valid = 1'b1; target = 8'b00000001;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (flags() !== 6'b001000 || cur !== exp[i]) begin
        errors++; $display("FAIL dec_step%0d flags=%b cur=%b exp=001000/%b", i, flags(), cur, exp[i]);
      end
    end
    tick();
    checks++;
    if (flags() !== 6'b000100) begin
      errors++; $display("FAIL dec_done got=%b exp=000100", flags());
    end
    tick();
  endtask

  task automatic test_equal();
    req_valid = 1'b1; target = 8'b00000001;
    tick();
    req_valid = 1'b0;
    checks++;
    if (flags() !== 6'b000000) begin
      errors++; $display("FAIL eq_accept got=%b exp=000000", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b000100 || cur !== 8'b00000001) begin
      errors++; $display("FAIL eq_done flags=%b cur=%b exp=000100/00000001", flags(), cur);
    end
    tick();
    checks++;
    if (flags() !== 6'b000001) begin
      errors++; $display("FAIL eq_ready got=%b exp=000001", flags());
    end
  endtask

  task automatic test_err();
    req_valid = 1'b1; target = 8'b00101111;
    tick();
    req_valid = 1'b0;
    checks++;
    if (flags() !== 6'b000011 || cur !== 8'b00000001) begin
      errors++; $display("FAIL err_target flags=%b cur=%b exp=000011/00000001", flags(), cur);
    end
    tick();
    checks++;
    if (flags() !== 6'b000001) begin
      errors++; $display("FAIL err_one_cycle got=%b exp=000001", flags());
    end
    load = 1'b1; load_val = 8'b01000000;
    tick();
    load = 1'b0;
    checks++;
    if (flags() !== 6'b000011 || cur !== 8'b00000001 || ffsr_init !== 8'b00000111) begin
      errors++; $display("FAIL err_load flags=%b cur=%b init=%b exp=000011/00000001/00000111",
                         flags(), cur, ffsr_init);
    end
    tick();
  endtask

  task automatic test_abort();
    req_valid = 1'b1; target = 8'b00011111;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (flags() !== 6'b010000 || cur !== 8'b00000111) begin
      errors++; $display("FAIL abort_pre flags=%b cur=%b exp=010000/00000111", flags(), cur);
    end
    load = 1'b1; load_val = 8'b00000000;
    tick();
    load = 1'b0;
    checks++;
    if (flags() !== 6'b100001 || cur !== 8'b0 || ffsr_init !== 8'b0) begin
      errors++; $display("FAIL abort_load flags=%b cur=%b init=%b exp=100001/0/0", flags(), cur, ffsr_init);
    end
    tick();
    checks++;
    if (flags() !== 6'b000001 || cur !== 8'b0) begin
      errors++; $display("FAIL abort_no_done flags=%b cur=%b exp=000001/0", flags(), cur);
    end
  endtask

  task automatic test_load_in_done();
    req_valid = 1'b1; target = 8'b00000001;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (flags() !== 6'b000100 || cur !== 8'b00000001) begin
      errors++; $display("FAIL done_pre flags=%b cur=%b exp=000100/00000001", flags(), cur);
    end
    load = 1'b1; load_val = 8'b00000011;
    tick();
    load = 1'b0;
    checks++;
    if (flags() !== 6'b100001 || cur !== 8'b00000011) begin
      errors++; $display("FAIL done_load flags=%b cur=%b exp=100001/00000011", flags(), cur);
    end
    tick();
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; target = 8'b00111111;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (flags() !== 6'b010000 || cur !== 8'b00000111) begin
      errors++; $display("FAIL arst_pre flags=%b cur=%b exp=010000/00000111", flags(), cur);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (flags() >> 1 !== 6'b0 || cur !== 8'b0 || ffsr_init !== 8'b0) begin
      errors++; $display("FAIL arst_async flags=%b cur=%b init=%b exp=00000x/0/0", flags(), cur, ffsr_init);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    tick();
    checks++;
    if (flags() !== 6'b000001 || cur !== 8'b0) begin
      errors++; $display("FAIL arst_no_replay flags=%b cur=%b exp=000001/0", flags(), cur);
    end
  endtask

`ifdef FFSR_PULSE_GEN_PACE_EN
  task automatic test_pace();
    logic [5:0] exp [1:8];
    exp = '{6'b010000, 6'b000000, 6'b000000, 6'b010000,
            6'b000000, 6'b000000, 6'b010000, 6'b000100};
    gap = 4'd2; req_valid = 1'b1; target = 8'b00000111;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (flags() !== exp[c]) begin
        errors++; $display("FAIL pace_cycle%0d got=%b exp=%b", c, flags(), exp[c]);
      end
    end
    gap = 4'd0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_inc();
    test_dec();
    test_equal();
    test_err();
    test_abort();
    test_load_in_done();
    test_async_reset();
`ifdef FFSR_PULSE_GEN_PACE_EN
    test_pace();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
